l2_write_buffer: RTL and testbench
==================================

L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports arb_read / arb_write  input  1 each  line read / line write request from the arbiter; held high until l2_resp.
REQ-004 SHALL have port arb_address  input  16  byte address; bits [3:0] ignored; line tag = [15:4].
REQ-005 SHALL have port arb_wdata  input  128  write line data.
REQ-006 SHALL have ports l2_resp  output  1  (one-cycle completion pulse) and l2_rdata  output  128  (read line data, valid while l2_resp=1).
REQ-007 SHALL have ports pmem_read / pmem_write  output  1 each, pmem_address  output  16 (bits [3:0]=0), pmem_wdata  output  128.
REQ-008 SHALL have ports pmem_rdata  input  128 and pmem_resp  input  1  physical memory completion.

Function
REQ-009 SHALL hold a one-entry buffer: wb_valid, wb_tag[11:0], wb_data[127:0].
REQ-010 SHALL implement states S_IDLE, S_READ_MEM, S_DRAIN, S_RESP.
REQ-011 SHALL, in S_IDLE with arb_write and (!wb_valid or wb_tag==arb_address[15:4]), load the buffer at that edge, set wb_valid, and go to S_RESP.
REQ-012 SHALL, in S_IDLE with arb_write and wb_valid and tag mismatch, go to S_DRAIN; the held write is re-evaluated on return to S_IDLE.
REQ-013 SHALL, in S_IDLE with arb_read and buffer tag hit, capture wb_data into the response register and go to S_RESP.
REQ-014 SHALL, in S_IDLE with arb_read and buffer miss, go to S_READ_MEM.
REQ-015 SHALL treat arb_read and arb_write both high as a write only.
REQ-016 SHALL, in S_IDLE with no request and wb_valid=1, go to S_DRAIN; a request present in S_IDLE always takes priority over this idle drain.
REQ-017 SHALL, in S_READ_MEM, drive pmem_read=1 and pmem_address={arb_address[15:4],4'h0}; on pmem_resp, capture pmem_rdata and go to S_RESP.
REQ-018 SHALL, in S_DRAIN, drive pmem_write=1, pmem_address={wb_tag,4'h0}, pmem_wdata=wb_data; on pmem_resp, clear wb_valid and go to S_IDLE.
REQ-019 SHALL, in S_RESP, assert l2_resp for exactly one cycle, drive l2_rdata from the response register, then go to S_IDLE.
REQ-020 SHALL let requesters drop arb_read/arb_write in the cycle after l2_resp; a request still high then is serviced as a new request.
REQ-021 SHALL ignore pmem_resp outside S_READ_MEM and S_DRAIN; pmem_read and pmem_write SHALL never both be 1.
REQ-022 SHALL give a write-hit or read-hit request latency of 2 cycles (S_IDLE to S_RESP, then the l2_resp cycle).
REQ-023 SHALL drive l2_rdata to 0 while l2_resp=0; pmem_address/pmem_wdata SHALL be 0 when no pmem request is active.

Reset
REQ-024 SHALL, on reset_n low at any time including mid-transaction, immediately enter S_IDLE, clear wb_valid, wb_tag, wb_data and the response register, and drive all outputs to 0.
REQ-025 SHALL drop any buffered write data on reset (not drained).

Configuration
REQ-026 SHALL, with macro L2_WRITE_BUFFER_EN defined, implement the buffer behaviour of REQ-009..REQ-018.
REQ-027 SHALL, without L2_WRITE_BUFFER_EN, contain no buffer, send writes from S_IDLE to S_DRAIN with pmem_* driven from arb_address/arb_wdata, go S_DRAIN->S_RESP on pmem_resp, always send reads to S_READ_MEM, and never perform an idle drain.

Verification
REQ-028 Reset, then write 0x1230 with data A while pmem idle -> l2_resp 2 cycles after request; then pmem_write to 0x1230 with data A on the next idle cycle.
REQ-029 Write 0x1230 data A, then immediately read 0x1238 -> l2_resp with l2_rdata=A, no pmem_read issued.
REQ-030 Write 0x1230 data A, then write 0x4560 data B with no idle gap -> pmem_write 0x1230/A completes first, then B is buffered and acknowledged.
REQ-031 Read 0x8000 miss, pmem_resp after 5 cycles with data C -> l2_resp exactly one cycle later with l2_rdata=C.
REQ-032 Assert reset_n low during S_DRAIN -> pmem_write drops asynchronously, wb_valid=0, and the first request after reset starts from S_IDLE.
REQ-033 Build without L2_WRITE_BUFFER_EN: write 0x1230 -> pmem_write 0x1230 precedes l2_resp; a following read 0x1230 issues pmem_read.

Source files
------------

// File: rtl/l2_write_buffer_if.sv
// Arbiter-side and physical-memory-side signals of the L2 write buffer.
// The slave modport is the buffer; the master modport is the arbiter plus memory environment.
interface l2_write_buffer_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    logic              arb_read;
    logic              arb_write;
    logic [ADDR_W-1:0] arb_address;
    logic [LINE_W-1:0] arb_wdata;
    logic              l2_resp;
    logic [LINE_W-1:0] l2_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  arb_read, arb_write, arb_address, arb_wdata,
        output l2_resp, l2_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output arb_read, arb_write, arb_address, arb_wdata,
        input  l2_resp, l2_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l2_write_buffer.sv
// One-line write buffer between the L2 arbiter and physical memory.
// Define L2_WRITE_BUFFER_EN to enable the buffer; otherwise writes go straight through to memory.
module l2_write_buffer (
    input  logic               clk,
    input  logic               reset_n,
    l2_write_buffer_if.slave   bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_READ_MEM, S_DRAIN, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [LINE_W-1:0] resp_q, resp_d;
    logic [TAG_W-1:0]  req_tag;
    logic              req_wr, req_rd;
    logic              unused_offset;

    // A simultaneous read and write is serviced as a write.
    assign req_tag       = bus.arb_address[ADDR_W-1:OFF_W];
    assign req_wr        = bus.arb_write;
    assign req_rd        = bus.arb_read & ~bus.arb_write;
    assign unused_offset = ^bus.arb_address[OFF_W-1:0];

`ifdef L2_WRITE_BUFFER_EN
    logic              wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
    logic [LINE_W-1:0] wb_data_q, wb_data_d;
    logic              wb_hit;

    assign wb_hit = wb_valid_q && (wb_tag_q == req_tag);

    // Buffered line; reset drops it without draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    // Next state, response capture and memory-side decode.
    always_comb begin
        state_d          = state_q;
        resp_d           = resp_q;
`ifdef L2_WRITE_BUFFER_EN
        wb_valid_d       = wb_valid_q;
        wb_tag_d         = wb_tag_q;
        wb_data_d        = wb_data_q;
`endif
        bus.l2_resp      = 1'b0;
        bus.l2_rdata     = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
`ifdef L2_WRITE_BUFFER_EN
                if (req_wr) begin
                    if (!wb_valid_q || wb_hit) begin
                        wb_valid_d = 1'b1;
                        wb_tag_d   = req_tag;
                        wb_data_d  = bus.arb_wdata;
                        resp_d     = '0;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_DRAIN;
                    end
                end else if (req_rd) begin
                    if (wb_hit) begin
                        resp_d  = wb_data_q;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_READ_MEM;
                    end
                end else if (wb_valid_q) begin
                    state_d = S_DRAIN;
                end
`else
                if (req_wr) begin
                    state_d = S_DRAIN;
                end else if (req_rd) begin
                    state_d = S_READ_MEM;
                end
`endif
            end
            S_READ_MEM: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_tag, {OFF_W{1'b0}}};
                if (bus.pmem_resp) begin
                    resp_d  = bus.pmem_rdata;
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                bus.pmem_write   = 1'b1;
`ifdef L2_WRITE_BUFFER_EN
                bus.pmem_address = {wb_tag_q, {OFF_W{1'b0}}};
                bus.pmem_wdata   = wb_data_q;
                if (bus.pmem_resp) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
`else
                bus.pmem_address = {req_tag, {OFF_W{1'b0}}};
                bus.pmem_wdata   = bus.arb_wdata;
                if (bus.pmem_resp) begin
                    resp_d  = '0;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                bus.l2_resp  = 1'b1;
                bus.l2_rdata = resp_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: coherent-memory scoreboard checked every cycle plus directed latency/ordering cases.
// Expectations follow whether L2_WRITE_BUFFER_EN is defined for the build.
module tb_l2_write_buffer;
`ifdef L2_WRITE_BUFFER_EN
    localparam bit BUF_EN     = 1'b1;
    localparam int W_LAT      = 2;
    localparam int W_NWR      = 0;
    localparam int DRAIN_NWR  = 2;
    localparam int HIT_LAT    = 2;
    localparam int HIT_NRD    = 0;
    localparam int MISS_W_LAT = 5;
`else
    localparam bit BUF_EN     = 1'b0;
    localparam int W_LAT      = 4;
    localparam int W_NWR      = 2;
    localparam int DRAIN_NWR  = 0;
    localparam int HIT_LAT    = 4;
    localparam int HIT_NRD    = 2;
    localparam int MISS_W_LAT = 4;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   mem_lat;
    bit   spurious;

    // Physical memory contents and the one line that is newer than memory.
    logic [127:0] phys [bit [11:0]];
    bit           pend_v;
    logic [11:0]  pend_tag;
    logic [127:0] pend_data;
    bit           wrote_cur;
    bit           prev_resp;

    l2_write_buffer_if bus();
    l2_write_buffer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] init_line(input logic [11:0] t);
        return {8{4'hA, t}};
    endfunction

    // Value a read of line t must return.
    function automatic logic [127:0] view(input logic [11:0] t);
        if (pend_v && pend_tag == t) return pend_data;
        if (phys.exists(t)) return phys[t];
        return init_line(t);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Physical memory: answers after mem_lat wait cycles; optional stray pmem_resp when idle.
    initial begin
        int wait_n;
        wait_n = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = '0;
            if (!reset_n) begin
                wait_n = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (wait_n >= mem_lat) begin
                    wait_n = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) phys[bus.pmem_address[15:4]] = bus.pmem_wdata;
                    else bus.pmem_rdata = phys.exists(bus.pmem_address[15:4]) ?
                                          phys[bus.pmem_address[15:4]] : init_line(bus.pmem_address[15:4]);
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
                if (spurious) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = '1;
                end
            end
        end
    end

    // Per-cycle compare against the scoreboard.
    initial begin
        logic [11:0] t;
        forever begin
            @(negedge clk);
            t = bus.arb_address[15:4];
            if (!reset_n) begin
                chk("rst_l2_resp", 128'(bus.l2_resp), 128'(0));
                chk("rst_l2_rdata", bus.l2_rdata, 128'(0));
                chk("rst_pmem_rw", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
                chk("rst_pmem_addr", 128'(bus.pmem_address), 128'(0));
                chk("rst_pmem_wdata", bus.pmem_wdata, 128'(0));
                pend_v    = 1'b0;
                wrote_cur = 1'b0;
                prev_resp = 1'b0;
            end else begin
                chk("pmem_rw_exclusive", 128'(bus.pmem_read & bus.pmem_write), 128'(0));
                if (!bus.l2_resp) chk("rdata_zero_idle", bus.l2_rdata, 128'(0));
                if (!bus.pmem_read && !bus.pmem_write) begin
                    chk("pmem_addr_idle", 128'(bus.pmem_address), 128'(0));
                    chk("pmem_wdata_idle", bus.pmem_wdata, 128'(0));
                end else begin
                    chk("pmem_addr_offset", 128'(bus.pmem_address[3:0]), 128'(0));
                end
                if (bus.pmem_read) begin
                    chk("pmem_read_for_read", 128'(bus.arb_read & ~bus.arb_write), 128'(1));
                    chk("pmem_read_addr", 128'(bus.pmem_address), 128'({t, 4'h0}));
                    if (BUF_EN) chk("pmem_read_on_hit", 128'(pend_v && pend_tag == t), 128'(0));
                end
                if (bus.pmem_write) begin
                    if (BUF_EN) begin
                        chk("drain_has_line", 128'(pend_v), 128'(1));
                        chk("drain_addr", 128'(bus.pmem_address), 128'({pend_tag, 4'h0}));
                        chk("drain_data", bus.pmem_wdata, pend_data);
                        if (bus.pmem_resp) pend_v = 1'b0;
                    end else begin
                        chk("wthru_for_write", 128'(bus.arb_write), 128'(1));
                        chk("wthru_addr", 128'(bus.pmem_address), 128'({t, 4'h0}));
                        chk("wthru_data", bus.pmem_wdata, bus.arb_wdata);
                        if (bus.pmem_resp) wrote_cur = 1'b1;
                    end
                end
                if (bus.l2_resp) begin
                    chk("resp_one_cycle", 128'(prev_resp), 128'(0));
                    chk("resp_has_req", 128'(bus.arb_read | bus.arb_write), 128'(1));
                    if (bus.arb_write) begin
                        if (BUF_EN) begin
                            if (pend_v) chk("ack_same_line", 128'(pend_tag), 128'(t));
                            pend_v    = 1'b1;
                            pend_tag  = t;
                            pend_data = bus.arb_wdata;
                        end else begin
                            chk("wthru_before_ack", 128'(wrote_cur), 128'(1));
                            wrote_cur = 1'b0;
                        end
                    end else if (bus.arb_read) begin
                        chk("read_data", bus.l2_rdata, view(t));
                    end
                end
                prev_resp = bus.l2_resp;
            end
        end
    end

    // Present a request in the current cycle, hold until l2_resp, drop it in the following cycle.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d,
                          output int lat, output int nrd, output int nwr, output int rsp_at,
                          output logic [127:0] rdata);
        bit done;
        done = 1'b0; lat = 0; nrd = 0; nwr = 0; rsp_at = -1; rdata = '0;
        bus.arb_read = rd; bus.arb_write = wr; bus.arb_address = a; bus.arb_wdata = d;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (bus.pmem_read) nrd++;
            if (bus.pmem_write) nwr++;
            if (bus.pmem_resp && (bus.pmem_read || bus.pmem_write)) rsp_at = lat;
            if (bus.l2_resp) begin
                rdata = bus.l2_rdata;
                done  = 1'b1;
            end
        end
        if (!done) chk("req_completes", 128'(bus.l2_resp), 128'(1));
        @(posedge clk); #1;
        bus.arb_read = 1'b0; bus.arb_write = 1'b0; bus.arb_address = '0; bus.arb_wdata = '0;
    endtask

    task automatic idle(input int n, output int nwr, output int first);
        nwr = 0; first = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (bus.pmem_write) begin
                nwr++;
                if (first == 0) first = c;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nrd, nwr, rsp_at, first, nw2, f2;
        logic [127:0] rd, ca, cb, cc, cd, ce;
        ca = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        cb = 128'hfeed_beef_cafe_f00d_1357_9bdf_2468_ace0;
        cc = 128'h0c0c_0c0c_1111_2222_3333_4444_5555_6666;
        cd = 128'hdddd_0000_dddd_0000_dddd_0000_dddd_0000;
        ce = 128'heeee_1234_eeee_5678_eeee_9abc_eeee_def0;
        checks = 0; errors = 0; mem_lat = 1; spurious = 1'b0;
        pend_v = 1'b0; wrote_cur = 1'b0; prev_resp = 1'b0;
        pend_tag = '0; pend_data = '0;
        reset_n = 1'b0;
        bus.arb_read = 1'b0; bus.arb_write = 1'b0; bus.arb_address = '0; bus.arb_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_l2_resp", 128'(bus.l2_resp), 128'(0));
        chk("reset_pmem_write", 128'(bus.pmem_write), 128'(0));
        chk("reset_pmem_read", 128'(bus.pmem_read), 128'(0));
        reset_n = 1'b1;

        // Single write, then the idle drain (buffered build only).
        do_req(1'b0, 1'b1, 16'h1230, ca, lat, nrd, nwr, rsp_at, rd);
        chk("w1_latency", 128'(lat), 128'(W_LAT));
        chk("w1_pmem_writes", 128'(nwr), 128'(W_NWR));
        idle(8, nw2, f2);
        chk("w1_idle_drain_cycles", 128'(nw2), 128'(DRAIN_NWR));
        if (BUF_EN) chk("w1_idle_drain_first", 128'(f2), 128'(2));
        chk("w1_mem_line", phys[12'h123], ca);

        // Write then immediate read of the same line.
        do_req(1'b0, 1'b1, 16'h1230, cb, lat, nrd, nwr, rsp_at, rd);
        chk("w2_latency", 128'(lat), 128'(W_LAT));
        do_req(1'b1, 1'b0, 16'h1238, '0, lat, nrd, nwr, rsp_at, rd);
        chk("r2_latency", 128'(lat), 128'(HIT_LAT));
        chk("r2_pmem_reads", 128'(nrd), 128'(HIT_NRD));
        chk("r2_data", rd, cb);
        idle(8, nw2, f2);

        // Back-to-back writes to different lines.
        do_req(1'b0, 1'b1, 16'h1230, ca, lat, nrd, nwr, rsp_at, rd);
        chk("w3a_latency", 128'(lat), 128'(W_LAT));
        do_req(1'b0, 1'b1, 16'h4560, cc, lat, nrd, nwr, rsp_at, rd);
        chk("w3b_latency", 128'(lat), 128'(MISS_W_LAT));
        chk("w3b_pmem_writes", 128'(nwr), 128'(2));
        chk("w3_first_line_in_mem", phys[12'h123], ca);
        if (BUF_EN) chk("w3_second_line_buffered", 128'(phys.exists(12'h456)), 128'(0));
        idle(8, nw2, f2);
        chk("w3_second_line_in_mem", phys[12'h456], cc);

        // Read miss with a slow memory.
        phys[12'h800] = cd;
        mem_lat = 4;
        do_req(1'b1, 1'b0, 16'h8000, '0, lat, nrd, nwr, rsp_at, rd);
        chk("r4_latency", 128'(lat), 128'(7));
        chk("r4_pmem_reads", 128'(nrd), 128'(5));
        chk("r4_resp_after_pmem", 128'(lat - rsp_at), 128'(1));
        chk("r4_data", rd, cd);
        mem_lat = 1;

        // Stray pmem_resp while idle is ignored.
        spurious = 1'b1;
        idle(5, nw2, f2);
        spurious = 1'b0;
        chk("stray_resp_no_write", 128'(nw2), 128'(0));
        do_req(1'b1, 1'b0, 16'h1234, '0, lat, nrd, nwr, rsp_at, rd);
        chk("r5_latency", 128'(lat), 128'(4));
        chk("r5_data", rd, ca);

        // Read and write together act as a write.
        do_req(1'b1, 1'b1, 16'hABC0, ce, lat, nrd, nwr, rsp_at, rd);
        chk("rw6_latency", 128'(lat), 128'(W_LAT));
        chk("rw6_pmem_reads", 128'(nrd), 128'(0));
        do_req(1'b1, 1'b0, 16'hABCC, '0, lat, nrd, nwr, rsp_at, rd);
        chk("r6_data", rd, ce);
        chk("r6_pmem_reads", 128'(nrd), 128'(HIT_NRD));
        idle(8, nw2, f2);

        // Reset in the middle of a drain.
        mem_lat = 20;
        if (BUF_EN) begin
            do_req(1'b0, 1'b1, 16'h9990, cd, lat, nrd, nwr, rsp_at, rd);
        end else begin
            bus.arb_write = 1'b1; bus.arb_address = 16'h9990; bus.arb_wdata = cd;
        end
        for (int c = 0; c < 10 && !bus.pmem_write; c++) @(negedge clk);
        chk("r7_drain_started", 128'(bus.pmem_write), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("r7_async_pmem_write", 128'(bus.pmem_write), 128'(0));
        chk("r7_async_pmem_addr", 128'(bus.pmem_address), 128'(0));
        bus.arb_write = 1'b0; bus.arb_address = '0; bus.arb_wdata = '0;
        mem_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("r7_line_dropped", 128'(phys.exists(12'h999)), 128'(0));
        do_req(1'b1, 1'b0, 16'h9990, '0, lat, nrd, nwr, rsp_at, rd);
        chk("r7_read_latency", 128'(lat), 128'(4));
        chk("r7_read_pmem", 128'(nrd), 128'(2));
        chk("r7_read_data", rd, init_line(12'h999));
        idle(4, nw2, f2);
        chk("r7_no_late_drain", 128'(nw2), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
